// File: rtl/mips_pipeline_ctrl.sv
// Hazard, stall and forwarding controller for the 5-stage MIPS pipeline.
// Freezes on pending memory access, inserts load-use bubbles, flushes on branches.
module mips_pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_IDrs,
  input  logic [4:0]       i_IDrt,
  input  logic             i_IDusesRt,
  input  logic [4:0]       i_EXrs,
  input  logic [4:0]       i_EXrt,
  input  logic [4:0]       i_EXwriteReg,
  input  logic             i_EXregWrite,
  input  logic             i_EXmemtoReg,
  input  logic             i_EXbranchTaken,
  input  logic [4:0]       i_MEMwriteReg,
  input  logic             i_MEMregWrite,
  input  logic             i_MEMmemtoReg,
  input  logic             i_MEMmemWrite,
  input  logic             i_memReady,
  input  logic [4:0]       i_WBwriteReg,
  input  logic             i_WBregWrite,
  output logic             o_pcWrite,
  output logic             o_ifidWrite,
  output logic             o_idexWrite,
  output logic             o_exmemWrite,
  output logic             o_ifidFlush,
  output logic             o_idexFlush,
  output logic [1:0]       o_forwardA,
  output logic [1:0]       o_forwardB,
  output logic             o_memErr,
  output logic [CNT_W-1:0] o_stallCount,
  output logic [CNT_W-1:0] o_flushCount
);

  typedef enum logic {RUN, WAIT} st_t;

  localparam logic [7:0]       TMO     = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  st_t              r_st;
  logic [7:0]       r_waitCnt;
  logic             r_memErr;
  logic [CNT_W-1:0] r_stallCount;
  logic [CNT_W-1:0] r_flushCount;

  st_t        w_stNxt;
  logic [7:0] w_waitNxt;
  logic       w_errNxt;
  logic       w_memReq;
  logic       w_timeoutHit;
  logic       w_memBusy;
  logic       w_loadUse;
  logic       w_branchCase;

  assign w_memReq     = i_MEMmemtoReg | i_MEMmemWrite;
  assign w_timeoutHit = (r_st == WAIT) && (r_waitCnt == TMO)
                        && !i_memReady;
  assign w_memBusy    = w_memReq & ~i_memReady & ~w_timeoutHit;
  assign w_loadUse    = i_EXmemtoReg & i_EXregWrite
                        & (i_EXwriteReg != 5'd0)
                        & ((i_EXwriteReg == i_IDrs)
                           | (i_IDusesRt & (i_EXwriteReg == i_IDrt)));
  assign w_branchCase = rst_n & ~w_memBusy & i_EXbranchTaken;

  function automatic logic [1:0] fwd(input logic [4:0] src);
    if (i_MEMregWrite && i_MEMwriteReg != 5'd0 && i_MEMwriteReg == src)
      return 2'b10;
    else if (i_WBregWrite && i_WBwriteReg != 5'd0 && i_WBwriteReg == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // State register: FSM, watchdog, sticky error and saturating counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st         <= RUN;
      r_waitCnt    <= 8'd0;
      r_memErr     <= 1'b0;
      r_stallCount <= '0;
      r_flushCount <= '0;
    end else begin
      r_st      <= w_stNxt;
      r_waitCnt <= w_waitNxt;
      r_memErr  <= w_errNxt;
      if (!o_pcWrite && r_stallCount != CNT_MAX)
        r_stallCount <= r_stallCount + CNT_ONE;
      if (w_branchCase && r_flushCount != CNT_MAX)
        r_flushCount <= r_flushCount + CNT_ONE;
    end
  end

  // Next-state logic: track how long the current memory access has waited
  always_comb begin
    w_stNxt   = r_st;
    w_waitNxt = r_waitCnt;
    w_errNxt  = r_memErr;
    unique case (r_st)
      RUN: begin
        if (w_memBusy) begin
          w_stNxt   = WAIT;
          w_waitNxt = 8'd1;
        end else begin
          w_waitNxt = 8'd0;
        end
      end
      WAIT: begin
        if (i_memReady) begin
          w_stNxt   = RUN;
          w_waitNxt = 8'd0;
        end else if (w_timeoutHit) begin
          w_errNxt  = 1'b1;
          w_stNxt   = RUN;
          w_waitNxt = 8'd0;
        end else begin
          w_waitNxt = r_waitCnt + 8'd1;
        end
      end
      default: begin
        w_stNxt   = RUN;
        w_waitNxt = 8'd0;
      end
    endcase
  end

  // Output logic: prioritised freeze / branch flush / load-use bubble
  always_comb begin
    o_pcWrite    = 1'b1;
    o_ifidWrite  = 1'b1;
    o_idexWrite  = 1'b1;
    o_exmemWrite = 1'b1;
    o_ifidFlush  = 1'b0;
    o_idexFlush  = 1'b0;
    o_forwardA   = fwd(i_EXrs);
    o_forwardB   = fwd(i_EXrt);
    if (!rst_n) begin
      o_pcWrite    = 1'b0;
      o_ifidWrite  = 1'b0;
      o_idexWrite  = 1'b0;
      o_exmemWrite = 1'b0;
      o_ifidFlush  = 1'b1;
      o_idexFlush  = 1'b1;
      o_forwardA   = 2'b00;
      o_forwardB   = 2'b00;
    end else if (w_memBusy) begin
      o_pcWrite    = 1'b0;
      o_ifidWrite  = 1'b0;
      o_idexWrite  = 1'b0;
      o_exmemWrite = 1'b0;
    end else if (i_EXbranchTaken) begin
      o_ifidFlush  = 1'b1;
      o_idexFlush  = 1'b1;
    end else if (w_loadUse) begin
      o_pcWrite    = 1'b0;
      o_ifidWrite  = 1'b0;
      o_idexFlush  = 1'b1;
    end
  end

  assign o_memErr     = r_memErr;
  assign o_stallCount = r_stallCount;
  assign o_flushCount = r_flushCount;

endmodule

// File: tb/tb_mips_pipeline_ctrl.sv
// Directed bench for mips_pipeline_ctrl: vector table plus
// multi-cycle sequences for memory wait, timeout, reset and saturation.
module tb_mips_pipeline_ctrl;

  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] IDrs, IDrt, EXrs, EXrt, EXwr, MEMwr, WBwr;
  logic IDusesRt, EXrw, EXm2r, EXbr, MEMrw, MEMm2r, MEMmw, rdy, WBrw;
  logic pcW, ifidW, idexW, exmemW, ifidF, idexF, memErr;
  logic [1:0] fa, fb;
  logic [CW-1:0] stallCnt, flushCnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_pipeline_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_IDrs(IDrs), .i_IDrt(IDrt), .i_IDusesRt(IDusesRt),
    .i_EXrs(EXrs), .i_EXrt(EXrt), .i_EXwriteReg(EXwr),
    .i_EXregWrite(EXrw), .i_EXmemtoReg(EXm2r),
    .i_EXbranchTaken(EXbr),
    .i_MEMwriteReg(MEMwr), .i_MEMregWrite(MEMrw),
    .i_MEMmemtoReg(MEMm2r), .i_MEMmemWrite(MEMmw),
    .i_memReady(rdy),
    .i_WBwriteReg(WBwr), .i_WBregWrite(WBrw),
    .o_pcWrite(pcW), .o_ifidWrite(ifidW),
    .o_idexWrite(idexW), .o_exmemWrite(exmemW),
    .o_ifidFlush(ifidF), .o_idexFlush(idexF),
    .o_forwardA(fa), .o_forwardB(fb),
    .o_memErr(memErr),
    .o_stallCount(stallCnt), .o_flushCount(flushCnt)
  );

  typedef struct {
    string      name;
    logic [4:0] IDrs, IDrt;
    logic       IDusesRt;
    logic [4:0] EXrs, EXrt, EXwr;
    logic       EXrw, EXm2r, EXbr;
    logic [4:0] MEMwr;
    logic       MEMrw, MEMm2r, MEMmw, rdy;
    logic [4:0] WBwr;
    logic       WBrw;
    logic [3:0] en;
    logic [1:0] fl;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t tv[$];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle();
    IDrs = 0; IDrt = 0; IDusesRt = 0;
    EXrs = 0; EXrt = 0; EXwr = 0;
    EXrw = 0; EXm2r = 0; EXbr = 0;
    MEMwr = 0; MEMrw = 0; MEMm2r = 0; MEMmw = 0; rdy = 0;
    WBwr = 0; WBrw = 0;
  endtask

  task automatic apply(vec_t v);
    IDrs = v.IDrs; IDrt = v.IDrt; IDusesRt = v.IDusesRt;
    EXrs = v.EXrs; EXrt = v.EXrt; EXwr = v.EXwr;
    EXrw = v.EXrw; EXm2r = v.EXm2r; EXbr = v.EXbr;
    MEMwr = v.MEMwr; MEMrw = v.MEMrw;
    MEMm2r = v.MEMm2r; MEMmw = v.MEMmw; rdy = v.rdy;
    WBwr = v.WBwr; WBrw = v.WBrw;
  endtask

  task automatic chk_ctl(string nm, logic [3:0] en, logic [1:0] fl);
    chk({nm, ".en"}, int'({pcW, ifidW, idexW, exmemW}), int'(en));
    chk({nm, ".fl"}, int'({ifidF, idexF}), int'(fl));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic run_timeout(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pcW) break;
      n++;
      cyc();
    end
  endtask

  function automatic vec_t mk(string nm,
      logic [4:0] idrs, logic [4:0] idrt, logic ur,
      logic [4:0] exrs, logic [4:0] exrt, logic [4:0] exwr,
      logic exrw, logic exm, logic br,
      logic [4:0] mwr, logic mrw, logic mm, logic mw, logic r,
      logic [4:0] wwr, logic wrw,
      logic [3:0] en, logic [1:0] fl, logic [1:0] a, logic [1:0] b);
    vec_t v;
    v.name = nm;
    v.IDrs = idrs; v.IDrt = idrt; v.IDusesRt = ur;
    v.EXrs = exrs; v.EXrt = exrt; v.EXwr = exwr;
    v.EXrw = exrw; v.EXm2r = exm; v.EXbr = br;
    v.MEMwr = mwr; v.MEMrw = mrw; v.MEMm2r = mm; v.MEMmw = mw;
    v.rdy = r; v.WBwr = wwr; v.WBrw = wrw;
    v.en = en; v.fl = fl; v.fa = a; v.fb = b;
    return v;
  endfunction

  int n;

  initial begin
    // name idrs idrt ur exrs exrt exwr exrw exm br
    //      mwr mrw mm mw rdy wwr wrw en fl fa fb
    tv.push_back(mk("idle", 0,0,0, 0,0,0, 0,0,0,
                    0,0,0,0,0, 0,0, 4'hF,2'b00,2'b00,2'b00));
    tv.push_back(mk("lu_rs", 5,0,0, 0,0,5, 1,1,0,
                    0,0,0,0,0, 0,0, 4'h3,2'b01,2'b00,2'b00));
    tv.push_back(mk("lu_r0", 0,0,0, 0,0,0, 1,1,0,
                    0,0,0,0,0, 0,0, 4'hF,2'b00,2'b00,2'b00));
    tv.push_back(mk("lu_rt", 1,6,1, 0,0,6, 1,1,0,
                    0,0,0,0,0, 0,0, 4'h3,2'b01,2'b00,2'b00));
    tv.push_back(mk("lu_rt_nouse", 1,6,0, 0,0,6, 1,1,0,
                    0,0,0,0,0, 0,0, 4'hF,2'b00,2'b00,2'b00));
    tv.push_back(mk("lu_norw", 5,0,0, 0,0,5, 0,1,0,
                    0,0,0,0,0, 0,0, 4'hF,2'b00,2'b00,2'b00));
    tv.push_back(mk("br_lu", 5,0,0, 0,0,5, 1,1,1,
                    0,0,0,0,0, 0,0, 4'hF,2'b11,2'b00,2'b00));
    tv.push_back(mk("br_lu_busy", 5,0,0, 0,0,5, 1,1,1,
                    0,0,1,0,0, 0,0, 4'h0,2'b00,2'b00,2'b00));
    tv.push_back(mk("mem_rdy", 0,0,0, 0,0,0, 0,0,0,
                    0,0,1,0,1, 0,0, 4'hF,2'b00,2'b00,2'b00));
    tv.push_back(mk("fwd_mem_pri", 0,0,0, 7,7,0, 0,0,0,
                    7,1,0,0,0, 7,1, 4'hF,2'b00,2'b10,2'b10));
    tv.push_back(mk("fwd_wb_b", 0,0,0, 3,9,0, 0,0,0,
                    3,1,0,0,0, 9,1, 4'hF,2'b00,2'b10,2'b01));
    tv.push_back(mk("fwd_r0", 0,0,0, 0,0,0, 0,0,0,
                    0,1,0,0,0, 0,1, 4'hF,2'b00,2'b00,2'b00));
    tv.push_back(mk("fwd_wb_only", 0,0,0, 7,2,0, 0,0,0,
                    7,0,0,0,0, 7,1, 4'hF,2'b00,2'b01,2'b00));
    tv.push_back(mk("fwd_busy", 0,0,0, 4,0,0, 0,0,0,
                    4,1,1,0,0, 0,0, 4'h0,2'b00,2'b10,2'b00));

    idle();
    EXrs = 7; MEMwr = 7; MEMrw = 1;
    rst_n = 1'b0;
    @(negedge clk);
    chk_ctl("rst", 4'h0, 2'b11);
    chk("rst.fa", int'(fa), 0);
    cyc();
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.memErr", int'(memErr), 0);
    chk("rst.stall", int'(stallCnt), 0);
    chk("rst.flush", int'(flushCnt), 0);
    cyc();

    foreach (tv[i]) begin
      apply(tv[i]);
      @(negedge clk);
      chk_ctl(tv[i].name, tv[i].en, tv[i].fl);
      chk({tv[i].name, ".fa"}, int'(fa), int'(tv[i].fa));
      chk({tv[i].name, ".fb"}, int'(fb), int'(tv[i].fb));
      cyc();
      idle();
      rdy = 1'b1;
      cyc();
      rdy = 1'b0;
    end

    // Memory wait of three cycles then completion
    idle();
    do_reset();
    MEMm2r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_ctl($sformatf("wait%0d", i), 4'h0, 2'b00);
      cyc();
    end
    rdy = 1'b1;
    @(negedge clk);
    chk_ctl("wait_rel", 4'hF, 2'b00);
    cyc();
    idle();
    @(negedge clk);
    chk("wait.stall", int'(stallCnt), 3);
    chk("wait.memErr", int'(memErr), 0);

    // Access that never completes: forced release after 15 stalls
    cyc();
    MEMmw = 1'b1;
    run_timeout(n);
    chk("tmo.stalls", n, 15);
    chk("tmo.errbefore", int'(memErr), 0);
    cyc();
    idle();
    @(negedge clk);
    chk("tmo.memErr", int'(memErr), 1);
    chk("tmo.stall", int'(stallCnt), 18);
    chk_ctl("tmo.run", 4'hF, 2'b00);
    cyc();

    // Branch beats load-use, then freeze beats branch
    apply(tv[6]);
    cyc();
    idle();
    @(negedge clk);
    chk("br.flush", int'(flushCnt), 1);
    chk("br.stall", int'(stallCnt), 18);
    apply(tv[7]);
    cyc();
    idle();
    @(negedge clk);
    chk("brbusy.flush", int'(flushCnt), 1);
    chk("brbusy.stall", int'(stallCnt), 19);
    rdy = 1'b1;
    cyc();
    rdy = 1'b0;

    // Reset in the middle of a wait
    MEMm2r = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b0;
    cyc();
    @(negedge clk);
    chk("midrst.memErr", int'(memErr), 0);
    chk("midrst.stall", int'(stallCnt), 0);
    chk_ctl("midrst", 4'h0, 2'b11);
    cyc();
    rst_n = 1'b1;
    run_timeout(n);
    chk("midrst.stalls", n, 15);

    // Repeated timeouts drive stallCount into saturation
    for (int i = 0; i < 40; i++) cyc();
    @(negedge clk);
    chk("sat.stall", int'(stallCnt), 31);
    chk("sat.memErr", int'(memErr), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
